// File: rtl/spectrum_bar_mapper_if.sv
// Frame handshake and bar-height bus between fft_16point, spectrum_bar_mapper and vga.
// master = upstream/consumer side (drives start/fft_flat), slave = the mapper itself.
interface spectrum_bar_mapper_if #(
    parameter int BAR_W = 18
);
    logic                   start;
    logic [575:0]           fft_flat;
    logic                   busy;
    logic                   done;
    logic [16*BAR_W-1:0]    bars_flat;
    logic [16*BAR_W-1:0]    peaks_flat;

    modport master (
        output start, fft_flat,
        input  busy, done, bars_flat, peaks_flat
    );

    modport slave (
        input  start, fft_flat,
        output busy, done, bars_flat, peaks_flat
    );
endinterface

// File: rtl/spectrum_bar_mapper.sv
// Maps 16 FFT bins to smoothed, clamped bar heights, one bin per clock, published atomically.
// Optional macro PEAK_HOLD_EN adds per-bin peak markers with a hold timer.
module spectrum_bar_mapper #(
    parameter int BAR_W       = 18,
    parameter int MAX_HEIGHT  = 400,
    parameter int SHIFT       = 4,
    parameter int DECAY_SHIFT = 2,
    parameter int HOLD_FRAMES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    spectrum_bar_mapper_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, PUBLISH} state_t;

    state_t              state_q, state_d;
    logic [35:0]         snap_q [16];
    logic [35:0]         snap_d [16];
    logic [BAR_W-1:0]    work_q [16];
    logic [BAR_W-1:0]    work_d [16];
    logic [3:0]          bin_q, bin_d;
    logic                done_q, done_d;
    logic [16*BAR_W-1:0] bars_q, bars_d;
    logic                busy;

    logic [17:0]         a_mag, b_mag, mx, mn;
    logic [18:0]         mag, mag_sh;
    logic [BAR_W-1:0]    tgt, cur, diff, step, smoothed;

    // -131072 has no positive 18-bit counterpart, so it saturates to 131071.
    function automatic logic [17:0] sat_abs(input logic [17:0] x);
        if (!x[17])
            return x;
        else if (x == 18'h20000)
            return 18'h1FFFF;
        else
            return 18'(-x);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (bin_q == 4'd15) state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        a_mag  = sat_abs(snap_q[bin_q][35:18]);
        b_mag  = sat_abs(snap_q[bin_q][17:0]);
        mx     = (a_mag >= b_mag) ? a_mag : b_mag;
        mn     = (a_mag >= b_mag) ? b_mag : a_mag;
        mag    = {1'b0, mx} + {2'b00, mn[17:1]};
        mag_sh = mag >> SHIFT;
        tgt    = (mag_sh > 19'(MAX_HEIGHT)) ? BAR_W'(MAX_HEIGHT) : BAR_W'(mag_sh);
        cur    = work_q[bin_q];
        diff   = cur - tgt;
        step   = diff >> DECAY_SHIFT;
        if (step == '0)
            step = BAR_W'(1);
        // step never exceeds diff when cur > tgt, so the decayed bar stays >= tgt.
        smoothed = (tgt >= cur) ? tgt : (cur - step);
    end

    always_comb begin
        snap_d = snap_q;
        work_d = work_q;
        bin_d  = bin_q;
        done_d = 1'b0;
        bars_d = bars_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int unsigned k = 0; k < 16; k++)
                        snap_d[k] = bus.fft_flat[36*k +: 36];
                    bin_d = '0;
                end
            end
            CALC: begin
                work_d[bin_q] = smoothed;
                bin_d         = bin_q + 4'd1;
            end
            PUBLISH: begin
                for (int unsigned k = 0; k < 16; k++)
                    bars_d[BAR_W*k +: BAR_W] = work_q[k];
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 16; k++) begin
                snap_q[k] <= '0;
                work_q[k] <= '0;
            end
            bin_q  <= '0;
            done_q <= 1'b0;
            bars_q <= '0;
        end else begin
            snap_q <= snap_d;
            work_q <= work_d;
            bin_q  <= bin_d;
            done_q <= done_d;
            bars_q <= bars_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.bars_flat = bars_q;

`ifdef PEAK_HOLD_EN
    localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

    logic [BAR_W-1:0]    peak_q [16];
    logic [BAR_W-1:0]    peak_d [16];
    logic [HOLD_W-1:0]   hold_q [16];
    logic [HOLD_W-1:0]   hold_d [16];
    logic [16*BAR_W-1:0] peaks_flat;

    // Peaks track the value being published this cycle, so they move with bars_flat.
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (state_q == PUBLISH) begin
            for (int unsigned k = 0; k < 16; k++) begin
                if (work_q[k] >= peak_q[k]) begin
                    peak_d[k] = work_q[k];
                    hold_d[k] = HOLD_W'(HOLD_FRAMES);
                end else if (hold_q[k] != '0) begin
                    hold_d[k] = hold_q[k] - HOLD_W'(1);
                end else begin
                    peak_d[k] = ((peak_q[k] - BAR_W'(1)) > work_q[k]) ?
                                (peak_q[k] - BAR_W'(1)) : work_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 16; k++) begin
                peak_q[k] <= '0;
                hold_q[k] <= '0;
            end
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    always_comb begin
        peaks_flat = '0;
        for (int unsigned k = 0; k < 16; k++)
            peaks_flat[BAR_W*k +: BAR_W] = peak_q[k];
    end

    assign bus.peaks_flat = peaks_flat;
`else
    assign bus.peaks_flat = '0;
`endif

endmodule

// File: tb/tb_spectrum_bar_mapper.sv
// Self-checking bench for spectrum_bar_mapper: directed table, corner sequences, random frames.
module tb_spectrum_bar_mapper;
    localparam int BAR_W = 18;
    localparam int MAXH  = 400;
    localparam int SH    = 4;
    localparam int DSH   = 2;
    localparam int HF    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spectrum_bar_mapper_if #(.BAR_W(BAR_W)) bus ();

    spectrum_bar_mapper #(
        .BAR_W(BAR_W), .MAX_HEIGHT(MAXH), .SHIFT(SH),
        .DECAY_SHIFT(DSH), .HOLD_FRAMES(HF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_work [16];
    int m_peak [16];
    int m_hold [16];

    typedef struct {
        int bin;
        int re;
        int im;
        int cb;
        int exp_bar;
        int exp_peak;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs_sat(input int x);
        int a;
        a = (x < 0) ? -x : x;
        if (a > 131071) a = 131071;
        return a;
    endfunction

    function automatic int model_tgt(input int re, input int im);
        int a, b, mx, mn, t;
        a  = iabs_sat(re);
        b  = iabs_sat(im);
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        t  = (mx + mn / 2) / (1 << SH);
        return (t > MAXH) ? MAXH : t;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_work[k] = 0;
            m_peak[k] = 0;
            m_hold[k] = 0;
        end
    endtask

    task automatic model_frame(input logic [575:0] v);
        int r, i, t, w, s;
        for (int k = 0; k < 16; k++) begin
            r = $signed(v[36*k+18 +: 18]);
            i = $signed(v[36*k +: 18]);
            t = model_tgt(r, i);
            w = m_work[k];
            if (t >= w) w = t;
            else begin
                s = (w - t) / (1 << DSH);
                if (s < 1) s = 1;
                w = w - s;
            end
            m_work[k] = w;
`ifdef PEAK_HOLD_EN
            if (w >= m_peak[k]) begin
                m_peak[k] = w;
                m_hold[k] = HF;
            end else if (m_hold[k] > 0) begin
                m_hold[k] = m_hold[k] - 1;
            end else begin
                m_peak[k] = (m_peak[k] - 1 > w) ? m_peak[k] - 1 : w;
            end
`else
            m_peak[k] = 0;
`endif
        end
    endtask

    task automatic check_bars(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s bar%0d", tag, k), 64'(bus.bars_flat[BAR_W*k +: BAR_W]), 64'(m_work[k]));
            chk($sformatf("%s peak%0d", tag, k), 64'(bus.peaks_flat[BAR_W*k +: BAR_W]), 64'(m_peak[k]));
        end
    endtask

    function automatic logic [575:0] one_bin(input int bin, input int re, input int im);
        logic [575:0] v;
        v = '0;
        if (bin >= 0) begin
            v[36*bin+18 +: 18] = 18'(re);
            v[36*bin +: 18]    = 18'(im);
        end
        return v;
    endfunction

    task automatic run_frame(input logic [575:0] v, input string tag);
        int  lat;
        int  busy_cnt;
        bit  got;
        lat = 0; busy_cnt = 0; got = 1'b0;
        @(negedge clk);
        bus.fft_flat = v;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.done) begin
                got = 1'b1;
                lat = i - 1;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        if (!got) begin
            chk({tag, " done timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, " latency"}, 64'(lat), 64'd17);
            chk({tag, " busy cycles"}, 64'(busy_cnt), 64'd17);
            chk({tag, " busy at done"}, 64'(bus.busy), 64'd0);
            model_frame(v);
            check_bars(tag);
            @(negedge clk);
            chk({tag, " done one cycle"}, 64'(bus.done), 64'd0);
        end
    endtask

    function automatic int rand_val();
        int mode;
        mode = int'($urandom_range(0, 3));
        case (mode)
            0: return 0;
            1: return int'($urandom_range(0, 8000)) - 4000;
            2: return int'($urandom_range(0, 262143)) - 131072;
            default: return -131072;
        endcase
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [575:0] v, v2;
        int done_cnt, done_at, extra;

        tbl[0] = '{3,  3200,   -1600, 3, 250, 250};
        tbl[1] = '{-1, 0,      0,     3, 188, 250};
        tbl[2] = '{-1, 0,      0,     3, 141, 250};
        tbl[3] = '{-1, 0,      0,     3, 106, 250};
        tbl[4] = '{-1, 0,      0,     3, 80,  249};
        tbl[5] = '{0,  -131072, 0,    0, 400, 400};
        tbl[6] = '{5,  16000,  16000, 5, 400, 400};
`ifndef PEAK_HOLD_EN
        for (int r = 0; r < 7; r++) tbl[r].exp_peak = 0;
`endif

        rst = 1'b1;
        bus.start = 1'b0;
        bus.fft_flat = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset bars", 64'(bus.bars_flat != '0), 64'd0);
        chk("reset peaks", 64'(bus.peaks_flat != '0), 64'd0);
        rst = 1'b0;

        for (int r = 0; r < 7; r++) begin
            run_frame(one_bin(tbl[r].bin, tbl[r].re, tbl[r].im), $sformatf("tbl%0d", r));
            chk($sformatf("tbl%0d exp bar", r),
                64'(bus.bars_flat[BAR_W*tbl[r].cb +: BAR_W]), 64'(tbl[r].exp_bar));
            chk($sformatf("tbl%0d exp peak", r),
                64'(bus.peaks_flat[BAR_W*tbl[r].cb +: BAR_W]), 64'(tbl[r].exp_peak));
        end

        for (int f = 0; f < 27; f++)
            run_frame('0, $sformatf("decay%0d", f));
        chk("decay bar3 zero", 64'(bus.bars_flat[BAR_W*3 +: BAR_W]), 64'd0);

        // second start five cycles into a frame must be ignored
        v  = one_bin(7, 5000, 100);
        v2 = one_bin(7, -131072, -131072);
        @(negedge clk);
        bus.fft_flat = v;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.fft_flat = v2;
        bus.start = 1'b1;
        done_cnt = 0;
        done_at = 0;
        for (int i = 5; i <= 45; i++) begin
            if (bus.done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (i == 5) begin
                @(negedge clk);
                bus.start = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("dblstart done count", 64'(done_cnt), 64'd1);
        chk("dblstart done time", 64'(done_at), 64'd18);
        model_frame(v);
        check_bars("dblstart");

        // start during the publish cycle must be ignored
        v = one_bin(9, 900, -7000);
        @(negedge clk);
        bus.fft_flat = v;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (16) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("pubstart done", 64'(bus.done), 64'd1);
        model_frame(v);
        check_bars("pubstart");
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) extra++;
        end
        chk("pubstart ignored", 64'(extra), 64'd0);

        // reset in the middle of CALC aborts the frame
        v = one_bin(2, 20000, 3);
        @(negedge clk);
        bus.fft_flat = v;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst busy before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst done", 64'(bus.done), 64'd0);
        chk("midrst bars", 64'(bus.bars_flat != '0), 64'd0);
        chk("midrst peaks", 64'(bus.peaks_flat != '0), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) extra++;
        end
        chk("midrst no done", 64'(extra), 64'd0);
        run_frame(one_bin(4, -3333, 12345), "postrst");

        // start coincident with reset: reset wins
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        bus.fft_flat = one_bin(1, 50000, 0);
        @(negedge clk);
        chk("rststart busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        bus.start = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rststart busy after", 64'(bus.busy), 64'd0);
        chk("rststart bars", 64'(bus.bars_flat != '0), 64'd0);

        for (int f = 0; f < 20; f++) begin
            v = '0;
            for (int k = 0; k < 16; k++) begin
                v[36*k+18 +: 18] = 18'(rand_val());
                v[36*k +: 18]    = 18'(rand_val());
            end
            run_frame(v, $sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
